put_list_drain_sched: RTL and testbench

//  Drain scheduler for the L2 put listbuffer (PUTLISTS linked lists over PUTBEATS shared beat slots).

---
 rtl/put_list_drain_sched_pkg.sv | 32 +++
 rtl/put_list_drain_sched_if.sv | 45 ++++
 rtl/put_list_drain_sched_rr_arb_pick.sv | 29 ++
 rtl/put_list_drain_sched.sv | 187 ++++++++++++++++++
 tb/tb_put_list_drain_sched.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/put_list_drain_sched_pkg.sv
// Shared definitions for the put-list drain scheduler: default geometry,
// FSM state encoding and the round-robin pointer helper.
// Optional feature macro used by the scheduler: PUT_SCHED_STALL_WDG_EN.
`ifndef PUTLISTS
`define PUTLISTS 4
`endif
`ifndef PUT_BITS
`define PUT_BITS 2
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef MASK_BITS
`define MASK_BITS 4
`endif

package put_list_drain_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  localparam int CNT_BITS_DEF  = 4;
  localparam int STALL_LIM_DEF = 64;

  // Next list after cur, wrapping at n.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/put_list_drain_sched_if.sv
// Bundle of the drain command, listbuffer and beat output channels.
// master = environment side, slave = scheduler side.
interface put_list_drain_sched_if #(
  parameter int PUTLISTS  = `PUTLISTS,
  parameter int PUT_BITS  = `PUT_BITS,
  parameter int DATA_BITS = `DATA_BITS,
  parameter int MASK_BITS = `MASK_BITS,
  parameter int CNT_BITS  = put_list_drain_sched_pkg::CNT_BITS_DEF
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [PUT_BITS-1:0]  req_idx_i;
  logic [CNT_BITS-1:0]  req_beats_i;
  logic [PUTLISTS-1:0]  lb_valid_i;
  logic                 lb_push_fire_i;
  logic [DATA_BITS-1:0] lb_data_i;
  logic [MASK_BITS-1:0] lb_mask_i;
  logic                 lb_pop_valid_o;
  logic [PUT_BITS-1:0]  lb_pop_idx_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DATA_BITS-1:0] out_data_o;
  logic [MASK_BITS-1:0] out_mask_o;
  logic [PUT_BITS-1:0]  out_idx_o;
  logic                 out_last_o;
  logic                 err_stall_o;

  modport master (
    output req_valid_i, req_idx_i, req_beats_i,
    output lb_valid_i, lb_push_fire_i, lb_data_i, lb_mask_i,
    output out_ready_i,
    input  req_ready_o, lb_pop_valid_o, lb_pop_idx_o,
    input  out_valid_o, out_data_o, out_mask_o, out_idx_o, out_last_o,
    input  err_stall_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, req_beats_i,
    input  lb_valid_i, lb_push_fire_i, lb_data_i, lb_mask_i,
    input  out_ready_i,
    output req_ready_o, lb_pop_valid_o, lb_pop_idx_o,
    output out_valid_o, out_data_o, out_mask_o, out_idx_o, out_last_o,
    output err_stall_o
  );
endinterface

// File: rtl/put_list_drain_sched_rr_arb_pick.sv
// Combinational round-robin pick: first eligible list at or after rr,
// wrapping, returned as a one-hot grant and a binary index.
module rr_arb_pick #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N-1:0]        elig_i,
  input  logic [IDX_BITS-1:0] rr_i,
  output logic [N-1:0]        grant_o,
  output logic [IDX_BITS-1:0] idx_o
);

  // Scan from the farthest offset down so the nearest eligible list wins.
  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_i) + k) % N;
      if (elig_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IDX_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/put_list_drain_sched.sv
// Drain scheduler for the L2 put listbuffer. Holds a pending-beat count per
// list, round-robins over lists with pending beats and data, pops one beat
// per cycle into a one-entry registered output stage and never interleaves
// two lists within a burst.
// Optional feature macro: PUT_SCHED_STALL_WDG_EN adds a stall watchdog that
// aborts a burst whose list stays empty for STALL_LIM cycles.
module put_list_drain_sched
  import put_list_drain_sched_pkg::*;
#(
  parameter int PUTLISTS  = `PUTLISTS,
  parameter int PUT_BITS  = `PUT_BITS,
  parameter int DATA_BITS = `DATA_BITS,
  parameter int MASK_BITS = `MASK_BITS,
  parameter int CNT_BITS  = CNT_BITS_DEF,
  parameter int STALL_LIM = STALL_LIM_DEF
) (
  input logic                  clk,
  input logic                  rst,
  put_list_drain_sched_if.slave bus
);

  sched_state_e         state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q [PUTLISTS];
  logic [CNT_BITS-1:0]  cnt_d [PUTLISTS];
  logic [PUT_BITS-1:0]  rr_q, rr_d;
  logic [PUT_BITS-1:0]  cur_q, cur_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic [MASK_BITS-1:0] out_mask_q, out_mask_d;
  logic [PUT_BITS-1:0]  out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;

  logic [PUTLISTS-1:0]  elig;
  logic [PUTLISTS-1:0]  grant;
  logic [PUT_BITS-1:0]  arb_idx;
  logic                 any_elig;
  logic                 req_ready;
  logic                 req_fire;
  logic                 fire;
  logic                 last_beat;
  logic [PUT_BITS-1:0]  cur_next;

`ifdef PUT_SCHED_STALL_WDG_EN
  localparam int STALL_W = $clog2(STALL_LIM + 1);
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 err_q, err_d;
`endif

  // A list is eligible when it has pending beats and the listbuffer holds data for it.
  always_comb begin
    for (int i = 0; i < PUTLISTS; i++) begin
      elig[i] = (cnt_q[i] != '0) & bus.lb_valid_i[i];
    end
  end

  rr_arb_pick #(
    .N        (PUTLISTS),
    .IDX_BITS (PUT_BITS)
  ) u_arb (
    .elig_i  (elig),
    .rr_i    (rr_q),
    .grant_o (grant),
    .idx_o   (arb_idx)
  );

  assign any_elig  = |grant;
  assign req_ready = (cnt_q[bus.req_idx_i] == '0);
  assign req_fire  = bus.req_valid_i & req_ready;
  // A push cycle blocks the pop: the listbuffer would lose the head update.
  assign fire      = (state_q == ST_BURST) & bus.lb_valid_i[cur_q] & ~bus.lb_push_fire_i &
                     (~out_valid_q | bus.out_ready_i);
  assign last_beat = (cnt_q[cur_q] == CNT_BITS'(1));
  assign cur_next  = PUT_BITS'(rr_next(int'(cur_q), PUTLISTS));

  assign bus.req_ready_o    = req_ready;
  assign bus.lb_pop_valid_o = fire;
  assign bus.lb_pop_idx_o   = cur_q;
  assign bus.out_valid_o    = out_valid_q;
  assign bus.out_data_o     = out_data_q;
  assign bus.out_mask_o     = out_mask_q;
  assign bus.out_idx_o      = out_idx_q;
  assign bus.out_last_o     = out_last_q;
`ifdef PUT_SCHED_STALL_WDG_EN
  assign bus.err_stall_o    = err_q;
`else
  assign bus.err_stall_o    = 1'b0;
`endif

  // Next-state: command intake, output stage, burst FSM and optional watchdog.
  always_comb begin
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    cur_d       = cur_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    // Accepted only on an idle list, so it never collides with a decrement.
    if (req_fire) begin
      cnt_d[bus.req_idx_i] = bus.req_beats_i;
    end

    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.lb_data_i;
      out_mask_d  = bus.lb_mask_i;
      out_idx_d   = cur_q;
      out_last_d  = last_beat;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          cur_d   = arb_idx;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (fire) begin
          cnt_d[cur_q] = cnt_q[cur_q] - 1'b1;
          if (last_beat) begin
            rr_d    = cur_next;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PUT_SCHED_STALL_WDG_EN
    stall_d = stall_q;
    err_d   = 1'b0;
    if ((state_q != ST_BURST) || fire) begin
      stall_d = '0;
    end else if (!bus.lb_valid_i[cur_q]) begin
      if (stall_q == STALL_W'(STALL_LIM - 1)) begin
        err_d        = 1'b1;
        stall_d      = '0;
        cnt_d[cur_q] = '0;
        rr_d         = cur_next;
        state_d      = ST_IDLE;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < PUTLISTS; i++) cnt_q[i] <= '0;
      rr_q        <= '0;
      cur_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef PUT_SCHED_STALL_WDG_EN
      stall_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      cur_q       <= cur_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef PUT_SCHED_STALL_WDG_EN
      stall_q     <= stall_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_put_list_drain_sched.sv
// Directed bench for put_list_drain_sched with a listbuffer stand-in and a
// beat scoreboard. Stall checks adapt to PUT_SCHED_STALL_WDG_EN.
module tb_put_list_drain_sched;

  localparam int PL = 4;
  localparam int PB = 2;
  localparam int DB = 32;
  localparam int MB = 4;
  localparam int CB = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   seq = 0;

  put_list_drain_sched_if #(.PUTLISTS(PL), .PUT_BITS(PB), .DATA_BITS(DB),
                            .MASK_BITS(MB), .CNT_BITS(CB)) bus ();

  put_list_drain_sched #(.PUTLISTS(PL), .PUT_BITS(PB), .DATA_BITS(DB),
                         .MASK_BITS(MB), .CNT_BITS(CB), .STALL_LIM(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Listbuffer contents {mask,data}, the copy used to build expectations,
  // and the expected beat stream {idx,last,mask,data}.
  logic [35:0] lb_q  [PL][$];
  logic [35:0] src_q [PL][$];
  logic [38:0] exp_q [$];
  int          pop_cyc_q [$];
  logic        pend_pop = 1'b0;
  logic [PB-1:0] pend_idx = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic refresh();
    logic [PL-1:0] v;
    logic [35:0]   h;
    for (int i = 0; i < PL; i++) v[i] = (lb_q[i].size() != 0);
    h = (lb_q[bus.lb_pop_idx_o].size() != 0) ? lb_q[bus.lb_pop_idx_o][0] : 36'h0;
    bus.lb_valid_i = v;
    bus.lb_data_i  = h[31:0];
    bus.lb_mask_i  = h[35:32];
  endtask

  // Listbuffer stand-in: retire the popped head, then present the new head.
  initial begin
    refresh();
    forever begin
      @(posedge clk);
      #1;
      if (pend_pop && lb_q[pend_idx].size() != 0) void'(lb_q[pend_idx].pop_front());
      #1;
      refresh();
    end
  end

  // Pop capture and beat scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [38:0] e;
    pend_pop = bus.lb_pop_valid_o & ~rst;
    pend_idx = bus.lb_pop_idx_o;
    if (!rst && bus.lb_pop_valid_o) pop_cyc_q.push_back(cyc);
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        timeout("beat_unexpected");
      end else begin
        e = exp_q.pop_front();
        check("beat", {25'h0, bus.out_idx_o, bus.out_last_o, bus.out_mask_o, bus.out_data_o},
              {25'h0, e});
      end
    end
  end

  task automatic load(input int i, input int n);
    logic [35:0] x;
    for (int k = 0; k < n; k++) begin
      seq++;
      x = {4'(seq + i), 8'(i), 8'(seq), 16'hBEEF};
      lb_q[i].push_back(x);
      src_q[i].push_back(x);
    end
  endtask

  task automatic expect_beats(input int i, input int n, input bit last_at_end);
    logic [35:0] x;
    for (int k = 0; k < n; k++) begin
      x = src_q[i].pop_front();
      exp_q.push_back({PB'(i), (last_at_end && k == n - 1), x});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < PL; i++) begin
      lb_q[i].delete();
      src_q[i].delete();
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pop_cyc_q.delete();
  endtask

  task automatic req(input int i, input int b);
    bit ok;
    ok = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_idx_i   = PB'(i);
    bus.req_beats_i = CB'(b);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("req_accept");
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_pop();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.lb_pop_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("wait_pop");
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pops;
    bit ok;
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_idx_i = '0; bus.req_beats_i = '0;
    bus.lb_push_fire_i = 1'b0; bus.out_ready_i = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_pop_valid", bus.lb_pop_valid_o, 0);
    check("rst_err", bus.err_stall_o, 0);
    check("rst_out_data", bus.out_data_o, 0);
    check("rst_out_last", bus.out_last_o, 0);
    check("rst_req_ready", bus.req_ready_o, 1);
    @(posedge clk); #1;

    // Single burst of 3 beats from list 2
    load(2, 3);
    expect_beats(2, 3, 1'b1);
    req(2, 3);
    drain("t1_drain");
    check("t1_pop_count", pop_cyc_q.size(), 3);
    if (pop_cyc_q.size() == 3) begin
      check("t1_pop_gap0", pop_cyc_q[1] - pop_cyc_q[0], 1);
      check("t1_pop_gap1", pop_cyc_q[2] - pop_cyc_q[1], 1);
    end
    bus.req_idx_i = 2'd2;
    @(negedge clk);
    check("t1_cnt_clear", bus.req_ready_o, 1);
    @(posedge clk); #1;

    // Round robin over lists 0,1,3 all requested before data arrives
    do_reset();
    req(3, 2); req(1, 2); req(0, 2);
    load(0, 2); load(1, 2); load(3, 2);
    expect_beats(0, 2, 1'b1); expect_beats(1, 2, 1'b1); expect_beats(3, 2, 1'b1);
    drain("t2_drain");
    // Pointer wrapped to 0: list 1 is served before list 3
    req(3, 1); req(1, 1);
    load(3, 1); load(1, 1);
    expect_beats(1, 1, 1'b1); expect_beats(3, 1, 1'b1);
    drain("t2_rr_wrap");

    // Push cycle blocks the second pop
    load(2, 2);
    expect_beats(2, 2, 1'b1);
    req(2, 2);
    wait_pop();
    @(posedge clk); #1;
    bus.lb_push_fire_i = 1'b1;
    @(negedge clk);
    check("t3_no_pop_on_push", bus.lb_pop_valid_o, 0);
    @(posedge clk); #1;
    bus.lb_push_fire_i = 1'b0;
    @(negedge clk);
    check("t3_pop_resume", bus.lb_pop_valid_o, 1);
    check("t3_pop_idx", bus.lb_pop_idx_o, 2);
    @(posedge clk); #1;
    drain("t3_drain");

    // Backpressure for 5 cycles mid-burst
    load(0, 5);
    expect_beats(0, 5, 1'b1);
    req(0, 5);
    wait_pop();
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_no_pop", bus.lb_pop_valid_o, 0);
      check("t4_hold_valid", bus.out_valid_o, 1);
      check("t4_hold_beat", {25'h0, bus.out_idx_o, bus.out_last_o, bus.out_mask_o, bus.out_data_o},
            {25'h0, exp_q[0]});
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_stream_pop", bus.lb_pop_valid_o, 1);
      @(posedge clk); #1;
    end
    drain("t4_drain");

    // Second request on a busy list waits for the last pop
    load(1, 3);
    expect_beats(1, 2, 1'b1);
    expect_beats(1, 1, 1'b1);
    req(1, 2);
    bus.req_valid_i = 1'b1; bus.req_idx_i = 2'd1; bus.req_beats_i = 4'd1;
    pops = 0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("t5_busy_refused", bus.req_ready_o, 0);
      if (bus.lb_pop_valid_o) pops++;
      if (pops == 2) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("t5_pops");
    @(negedge clk);
    check("t5_accept_after_last", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    drain("t5_drain");

    // List empties mid-burst
    load(2, 2);
    expect_beats(2, 2, 1'b0);
    req(2, 5);
    pops = 0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.lb_pop_valid_o) pops++;
      if (pops == 2) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("t6_pops");
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
`ifdef PUT_SCHED_STALL_WDG_EN
      check("t6_err_pulse", bus.err_stall_o, (n == 9));
`else
      check("t6_err_quiet", bus.err_stall_o, 0);
      check("t6_wait_no_pop", bus.lb_pop_valid_o, 0);
`endif
    end
    @(posedge clk); #1;
`ifdef PUT_SCHED_STALL_WDG_EN
    bus.req_idx_i = 2'd2;
    @(negedge clk);
    check("t6_cnt_cleared", bus.req_ready_o, 1);
    @(posedge clk); #1;
    load(2, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_idle_no_pop", bus.lb_pop_valid_o, 0);
    end
    @(posedge clk); #1;
`else
    load(2, 3);
    expect_beats(2, 3, 1'b1);
    drain("t6_resume_drain");
    bus.req_idx_i = 2'd2;
    @(negedge clk);
    check("t6_cnt_clear", bus.req_ready_o, 1);
    @(posedge clk); #1;
`endif

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
